// File: rtl/alu_pkg.sv
// Shared definitions for clients of the combinational ALU: select encodings,
// the issue FSM state type, the divide-by-zero result and settle latencies.
package alu_pkg;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_MULT = 3'b010;
  localparam logic [2:0] SEL_DIV  = 3'b011;
  localparam logic [2:0] SEL_OR   = 3'b100;
  localparam logic [2:0] SEL_AND  = 3'b101;
  localparam logic [2:0] SEL_SLT  = 3'b110;
  localparam logic [2:0] SEL_SLL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Wide enough for any WIDTH up to 64; clients slice the low bits.
  localparam logic [63:0] DIV_ZERO_RESULT = '1;

  function automatic int unsigned op_latency(
    input logic [2:0]  sel,
    input int unsigned lat_base,
    input int unsigned lat_mul,
    input int unsigned lat_div
  );
    case (sel)
      SEL_MULT: op_latency = lat_mul;
      SEL_DIV:  op_latency = lat_div;
      default:  op_latency = lat_base;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time onto the ALU ports, waits the per-operation
// settle latency, then holds the captured result until downstream takes it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LAT_BASE = 1,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [WIDTH-1:0] Req_Op1,
  input  logic [WIDTH-1:0] Req_Op2,
  input  logic [2:0]       Req_Sel,
  output logic [WIDTH-1:0] Alu_Op1,
  output logic [WIDTH-1:0] Alu_Op2,
  output logic [2:0]       Alu_S_Op,
  input  logic [WIDTH-1:0] Alu_R_Op,
  input  logic             Alu_ZF,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic [WIDTH-1:0] Rsp_Data,
  output logic             Rsp_ZF,
  output logic             Rsp_DivZero,
  output logic             Busy
);

  localparam int unsigned LAT_MAX_BM = (LAT_BASE > LAT_MUL) ? LAT_BASE : LAT_MUL;
  localparam int unsigned LAT_MAX    = (LAT_MAX_BM > LAT_DIV) ? LAT_MAX_BM : LAT_DIV;
  localparam int unsigned CNT_W      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             div_zero_reg;
  logic             accept;
  logic             req_div_zero;
  logic             settle_done;

  assign accept       = Req_Valid && Req_Ready;
  assign req_div_zero = (Req_Sel == SEL_DIV) && (Req_Op2 == '0);
  assign settle_done  = (state_reg == SETTLE) && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A divide by zero still passes through SETTLE for one cycle so that every
  // operation, suppressed or not, answers no earlier than one cycle after accept.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SETTLE;
      SETTLE:  if (cnt_reg == '0) state_next = RESP;
      RESP: begin
        if (accept)         state_next = SETTLE;
        else if (Rsp_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Req_Ready = rst_n && ((state_reg == IDLE) || ((state_reg == RESP) && Rsp_Ready));
    Rsp_Valid = (state_reg == RESP);
    Busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Alu_Op1      <= '0;
      Alu_Op2      <= '0;
      Alu_S_Op     <= SEL_ADD;
      cnt_reg      <= '0;
      div_zero_reg <= 1'b0;
      Rsp_Data     <= '0;
      Rsp_ZF       <= 1'b0;
      Rsp_DivZero  <= 1'b0;
    end else begin
      if (accept) begin
        div_zero_reg <= req_div_zero;
        if (req_div_zero) begin
          cnt_reg <= '0;
        end else begin
          Alu_Op1  <= Req_Op1;
          Alu_Op2  <= Req_Op2;
          Alu_S_Op <= Req_Sel;
          cnt_reg  <= CNT_W'(op_latency(Req_Sel, LAT_BASE, LAT_MUL, LAT_DIV) - 1);
        end
      end else if ((state_reg == SETTLE) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end

      if (settle_done) begin
        if (div_zero_reg) begin
          Rsp_Data    <= DIV_ZERO_RESULT[WIDTH-1:0];
          Rsp_ZF      <= 1'b0;
          Rsp_DivZero <= 1'b1;
        end else begin
          Rsp_Data    <= Alu_R_Op;
          Rsp_ZF      <= Alu_ZF;
          Rsp_DivZero <= 1'b0;
        end
      end
    end
  end

endmodule
